// File: rtl/cache_link_master_if.sv
// Bundle of every cache_link_master signal except clk/rst_n.
//   master : the host-side initiator (cache_link_master itself)
//   slave  : whatever drives it -- local command/data logic plus the
//            daughter-card end of the E-port link
// Local side : link_ready, cmd_valid, cmd_rd, cmd_ready, abort,
//              wr_data_req, wr_data, rd_data, rd_data_valid, done, words, busy
// Link side  : rw_cmd (active-low strobe), rd_bstop, conn_out, conn_in
interface cache_link_master_if;
  logic        link_ready;
  logic        cmd_valid;
  logic        cmd_rd;
  logic        cmd_ready;
  logic        abort;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        done;
  logic [9:0]  words;
  logic        busy;
  logic        rw_cmd;
  logic        rd_bstop;
  logic [15:0] conn_out;
  logic [15:0] conn_in;

  modport master (
    input  link_ready, cmd_valid, cmd_rd, abort, wr_data, conn_in,
    output cmd_ready, wr_data_req, rd_data, rd_data_valid, done, words, busy,
           rw_cmd, rd_bstop, conn_out
  );

  modport slave (
    output link_ready, cmd_valid, cmd_rd, abort, wr_data, conn_in,
    input  cmd_ready, wr_data_req, rd_data, rd_data_valid, done, words, busy,
           rw_cmd, rd_bstop, conn_out
  );
endinterface

// File: rtl/cache_link_master.sv
// Host-side initiator for the V1495 E-port link to the daughter-card SDRAM
// cache. Accepts one burst command at a time, strobes rw_cmd low for one
// cycle (T0) with the direction on conn_out[15], then either streams BURST
// words from an FWFT source onto conn_out or captures BURST words from
// conn_in at a fixed latency. A guard interval follows every burst so the
// daughter card can clear its counters/FIFOs before the next command.
// Ports:
//   clk    system clock (shared with the daughter card)
//   rst_n  asynchronous active-low reset
//   bus    cache_link_master_if.master -- local command/data side and link side
module cache_link_master #(
  parameter int unsigned BURST   = 256,
  parameter int unsigned WR_LEAD = 3,
  parameter int unsigned RD_LAT  = 21,
  parameter int unsigned GUARD   = 24
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_link_master_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_GUARD   = 3'd4;

  // cnt is 0 in the first cycle of each state; the data states start at T0+1.
  localparam logic [9:0] WR_FIRST  = 10'(WR_LEAD - 2);          // first pop
  localparam logic [9:0] WR_LAST   = 10'(WR_LEAD + BURST - 3);  // last pop
  localparam logic [9:0] WR_END    = 10'(WR_LEAD + BURST - 2);  // last word on conn_out
  localparam logic [9:0] RD_FIRST  = 10'(RD_LAT - 1);           // first conn_in sample
  localparam logic [9:0] RD_END    = 10'(RD_LAT + BURST - 2);   // last conn_in sample
  localparam logic [9:0] GUARD_END = 10'(GUARD - 1);

  logic [2:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  words_q, words_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        rw_cmd_q, rw_cmd_d;
  logic        rd_bstop_q, rd_bstop_d;
  logic        rd_data_valid_q, rd_data_valid_d;
  logic [15:0] conn_out_q, conn_out_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        accept, wr_req, rd_sample;

  always_comb begin
    accept    = (state_q == S_IDLE) && bus.link_ready && bus.cmd_valid;
    wr_req    = (state_q == S_WR_DATA) && (cnt_q >= WR_FIRST) && (cnt_q <= WR_LAST);
    rd_sample = (state_q == S_RD_DATA) && (cnt_q >= RD_FIRST);

    state_d         = state_q;
    cmd_rd_d        = cmd_rd_q;
    words_d         = words_q;
    rw_cmd_d        = 1'b1;
    rd_bstop_d      = 1'b0;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    conn_out_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_CMD;
          cmd_rd_d   = bus.cmd_rd;
          words_d    = '0;
          rw_cmd_d   = 1'b0;
          conn_out_d = {bus.cmd_rd, 15'b0};
        end
      end
      S_CMD: begin
        state_d = cmd_rd_q ? S_RD_DATA : S_WR_DATA;
      end
      S_WR_DATA: begin
        // The popped word is registered straight onto the link next cycle.
        if (wr_req) begin
          conn_out_d = bus.wr_data;
          words_d    = words_q + 10'd1;
        end
        if (cnt_q == WR_END) state_d = S_GUARD;
      end
      S_RD_DATA: begin
        // A sample in the abort cycle is still kept; nothing after it is.
        if (rd_sample) begin
          rd_data_d       = bus.conn_in;
          rd_data_valid_d = 1'b1;
          words_d         = words_q + 10'd1;
        end
        if (bus.abort) begin
          rd_bstop_d = 1'b1;
          state_d    = S_GUARD;
        end else if (cnt_q == RD_END) begin
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (cnt_q == GUARD_END) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      words_q         <= '0;
      cmd_rd_q        <= 1'b0;
      rw_cmd_q        <= 1'b1;
      rd_bstop_q      <= 1'b0;
      rd_data_valid_q <= 1'b0;
      conn_out_q      <= '0;
      rd_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      words_q         <= words_d;
      cmd_rd_q        <= cmd_rd_d;
      rw_cmd_q        <= rw_cmd_d;
      rd_bstop_q      <= rd_bstop_d;
      rd_data_valid_q <= rd_data_valid_d;
      conn_out_q      <= conn_out_d;
      rd_data_q       <= rd_data_d;
    end
  end

  // rst_n gating keeps cmd_ready low throughout reset even with link_ready up.
  assign bus.cmd_ready     = rst_n && (state_q == S_IDLE) && bus.link_ready;
  assign bus.wr_data_req   = wr_req;
  assign bus.done          = (state_q == S_GUARD) && (cnt_q == GUARD_END);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.words         = words_q;
  assign bus.rw_cmd        = rw_cmd_q;
  assign bus.rd_bstop      = rd_bstop_q;
  assign bus.conn_out      = conn_out_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_data_valid_q;

endmodule
